// File: rtl/conv_tile_sched.sv
// conv_tile_sched
//   Tile sequencer for the convolution accelerator. It walks the output volume
//   in this loop order: tile_out (outermost), then tile_row, then tile_col.
//   For each output tile it runs a load/compute pair for every input-channel
//   tile and then issues one store. Every stage is started with a one-cycle
//   pulse and acknowledged with a one-cycle done pulse.
//
// Ports
//   clk_i, rst_i          clock, synchronous active-high reset
//   conv_start_i          start a full layer; only honoured when idle
//   load_start_o          load the tile at the current indices
//   load_done_i           load acknowledged
//   compute_start_o       run the PE array on the loaded tile
//   acc_clear_o           qualifies compute_start_o: first input tile, clear accumulators
//   compute_done_i        compute acknowledged
//   store_start_o         dump the output tile and write it back to DDR
//   store_done_i          both store paths finished
//   tile_row_o/col_o/in_o/out_o  current tile indices
//   busy_o                high whenever the sequencer is not idle
//   conv_done_o           last store of the layer acknowledged
module conv_tile_sched #(
  parameter int TILE_ROW_NUM = 4,
  parameter int TILE_COL_NUM = 4,
  parameter int TILE_IN_NUM  = 2,
  parameter int TILE_OUT_NUM = 2,
  parameter int CW           = 8
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          conv_start_i,
  output logic          load_start_o,
  input  logic          load_done_i,
  output logic          compute_start_o,
  output logic          acc_clear_o,
  input  logic          compute_done_i,
  output logic          store_start_o,
  input  logic          store_done_i,
  output logic [CW-1:0] tile_row_o,
  output logic [CW-1:0] tile_col_o,
  output logic [CW-1:0] tile_in_o,
  output logic [CW-1:0] tile_out_o,
  output logic          busy_o,
  output logic          conv_done_o
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WAIT_LOAD, S_COMP, S_WAIT_COMP,
    S_STORE, S_WAIT_STORE, S_NEXT, S_FIN
  } state_e;

  localparam logic [CW-1:0] ROW_LAST = CW'(TILE_ROW_NUM - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(TILE_COL_NUM - 1);
  localparam logic [CW-1:0] IN_LAST  = CW'(TILE_IN_NUM - 1);
  localparam logic [CW-1:0] OUT_LAST = CW'(TILE_OUT_NUM - 1);

  state_e        state_q, state_d;
  logic [CW-1:0] row_q, row_d, col_q, col_d, in_q, in_d, out_q, out_d;

  logic load_start_q, load_start_d;
  logic compute_start_q, compute_start_d;
  logic acc_clear_q, acc_clear_d;
  logic store_start_q, store_start_d;
  logic busy_q, busy_d;
  logic conv_done_q, conv_done_d;

  // State, index and output registers
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q         <= S_IDLE;
      row_q           <= '0;
      col_q           <= '0;
      in_q            <= '0;
      out_q           <= '0;
      load_start_q    <= 1'b0;
      compute_start_q <= 1'b0;
      acc_clear_q     <= 1'b0;
      store_start_q   <= 1'b0;
      busy_q          <= 1'b0;
      conv_done_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      col_q           <= col_d;
      in_q            <= in_d;
      out_q           <= out_d;
      load_start_q    <= load_start_d;
      compute_start_q <= compute_start_d;
      acc_clear_q     <= acc_clear_d;
      store_start_q   <= store_start_d;
      busy_q          <= busy_d;
      conv_done_q     <= conv_done_d;
    end
  end

  // Next state and index stepping. Done inputs are only looked at in their
  // own wait state, so stray or stretched pulses fall on the floor.
  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    in_d    = in_q;
    out_d   = out_q;
    case (state_q)
      S_IDLE:       if (conv_start_i) state_d = S_LOAD;
      S_LOAD:       state_d = S_WAIT_LOAD;
      S_WAIT_LOAD:  if (load_done_i) state_d = S_COMP;
      S_COMP:       state_d = S_WAIT_COMP;
      S_WAIT_COMP: begin
        if (compute_done_i) begin
          if (in_q == IN_LAST) begin
            state_d = S_STORE;
          end else begin
            in_d    = in_q + 1'b1;
            state_d = S_LOAD;
          end
        end
      end
      S_STORE:      state_d = S_WAIT_STORE;
      S_WAIT_STORE: if (store_done_i) state_d = S_NEXT;
      S_NEXT: begin
        // Odometer step: col fastest, then row, then out.
        in_d    = '0;
        state_d = S_LOAD;
        if (col_q == COL_LAST) begin
          col_d = '0;
          if (row_q == ROW_LAST) begin
            row_d = '0;
            if (out_q == OUT_LAST) begin
              out_d   = '0;
              state_d = S_FIN;
            end else begin
              out_d = out_q + 1'b1;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_FIN: begin
        row_d   = '0;
        col_d   = '0;
        in_d    = '0;
        out_d   = '0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are decoded from the next state and registered, so each pulse
  // lines up exactly with the cycle the FSM sits in the matching state.
  always_comb begin
    load_start_d    = (state_d == S_LOAD);
    compute_start_d = (state_d == S_COMP);
    acc_clear_d     = (state_d == S_COMP) && (in_d == '0);
    store_start_d   = (state_d == S_STORE);
    conv_done_d     = (state_d == S_FIN);
    busy_d          = (state_d != S_IDLE);
  end

  assign load_start_o    = load_start_q;
  assign compute_start_o = compute_start_q;
  assign acc_clear_o     = acc_clear_q;
  assign store_start_o   = store_start_q;
  assign busy_o          = busy_q;
  assign conv_done_o     = conv_done_q;
  assign tile_row_o      = row_q;
  assign tile_col_o      = col_q;
  assign tile_in_o       = in_q;
  assign tile_out_o      = out_q;

endmodule

// File: tb/tb_conv_tile_sched.sv
// Bench for conv_tile_sched. dut runs ROW=2,COL=2,IN=2,OUT=1; dut1 runs all
// counts at 1. The reference is an event list built from nested loops over
// the tile space, checked pulse by pulse, plus literal counts and timings.
module tb_conv_tile_sched;
  localparam int CW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic cs = 1'b0, cs1 = 1'b0;
  logic ld_st, cp_st, acc, st_st, busy, cdone;
  logic ld_r = 1'b0, cp_r = 1'b0, st_r = 1'b0;
  logic ld_sp = 1'b0, cp_sp = 1'b0, st_sp = 1'b0;
  logic ld_dn, cp_dn, st_dn;
  logic [CW-1:0] trow, tcol, tin, tout;
  logic ld_st1, cp_st1, acc1, st_st1, busy1, cdone1;
  logic ld_dn1 = 1'b0, cp_dn1 = 1'b0, st_dn1 = 1'b0;
  logic [CW-1:0] trow1, tcol1, tin1, tout1;

  assign ld_dn = ld_r | ld_sp;
  assign cp_dn = cp_r | cp_sp;
  assign st_dn = st_r | st_sp;

  conv_tile_sched #(.TILE_ROW_NUM(2), .TILE_COL_NUM(2), .TILE_IN_NUM(2),
                    .TILE_OUT_NUM(1), .CW(CW)) dut (
    .clk_i(clk), .rst_i(rst), .conv_start_i(cs),
    .load_start_o(ld_st), .load_done_i(ld_dn),
    .compute_start_o(cp_st), .acc_clear_o(acc), .compute_done_i(cp_dn),
    .store_start_o(st_st), .store_done_i(st_dn),
    .tile_row_o(trow), .tile_col_o(tcol), .tile_in_o(tin), .tile_out_o(tout),
    .busy_o(busy), .conv_done_o(cdone));

  conv_tile_sched #(.TILE_ROW_NUM(1), .TILE_COL_NUM(1), .TILE_IN_NUM(1),
                    .TILE_OUT_NUM(1), .CW(CW)) dut1 (
    .clk_i(clk), .rst_i(rst), .conv_start_i(cs1),
    .load_start_o(ld_st1), .load_done_i(ld_dn1),
    .compute_start_o(cp_st1), .acc_clear_o(acc1), .compute_done_i(cp_dn1),
    .store_start_o(st_st1), .store_done_i(st_dn1),
    .tile_row_o(trow1), .tile_col_o(tcol1), .tile_in_o(tin1), .tile_out_o(tout1),
    .busy_o(busy1), .conv_done_o(cdone1));

  typedef struct {int kind; int r; int c; int i; int o; int acc; int gap;} ev_t;
  ev_t q[$];

  int n_chk = 0, n_err = 0, cyc = 0;
  // one-shot inputs for the next cycle
  logic p_rst = 1'b0, p_cs = 1'b0, p_cs1 = 1'b0, p_ld = 1'b0, p_cp = 1'b0, p_st = 1'b0;
  // responders: done arrives d cycles after the start pulse
  int c_ld = 0, c_cp = 0, c_st = 0, d_ld = 3, d_cp = 3, d_st = 3;
  int c_ld1 = 0, c_cp1 = 0, c_st1 = 0, d_st1 = 100;
  // model state
  logic exp_busy = 1'b0, lat_chk = 1'b0, saw_done = 1'b0;
  int last_in = 0, cs_cyc = 0, cd_cyc = 0;
  // logs
  int n_ld = 0, n_cp = 0, n_st = 0, n_cd = 0;
  int acc_log[64], st_row[32], st_col[32], st_in[32];
  int n_ld1 = 0, n_cp1 = 0, n_st1 = 0, n_cd1 = 0, acc1_seen = 0;
  int sd1_cyc = -1, cd1_cyc = -1, cs1_cyc = 0;
  logic [31:0] idx1 = '1;
  logic busy1_at_sd = 1'b0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    end
  endtask

  task automatic resp(inout int c, output logic dn, input logic st, input int d);
    dn = 1'b0;
    if (c > 0) begin
      c--;
      if (c == 0) dn = 1'b1;
    end
    if (st) c = d;
  endtask

  // Expected pulse sequence for one layer of the 2x2x2x1 instance.
  task automatic build();
    for (int o = 0; o < 1; o++)
      for (int r = 0; r < 2; r++)
        for (int c = 0; c < 2; c++) begin
          for (int i = 0; i < 2; i++) begin
            q.push_back('{0, r, c, i, o, 0,
                          (i > 0 || (r == 0 && c == 0 && o == 0)) ? 1 : 2});
            q.push_back('{1, r, c, i, o, (i == 0) ? 1 : 0, 1});
          end
          q.push_back('{2, r, c, 1, o, 0, 1});
        end
    q.push_back('{3, 0, 0, 0, 0, 0, 2});
  endtask

  task automatic check();
    ev_t e;
    logic p, acc_start;
    if (rst) begin
      q.delete();
      exp_busy = 1'b0;
      return;
    end
    chk("busy", busy, exp_busy);
    for (int k = 0; k < 4; k++) begin
      p = (k == 0) ? ld_st : (k == 1) ? cp_st : (k == 2) ? st_st : cdone;
      if (p) begin
        if (q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_pulse: got kind %0d expected none (cycle %0d)", k, cyc);
        end else begin
          e = q.pop_front();
          acc_start = (k == 1) ? acc : 1'b0;
          chk("event", {8'(k), trow, tcol, tin, tout, 8'(acc_start)},
              {8'(e.kind), 8'(e.r), 8'(e.c), 8'(e.i), 8'(e.o), 8'(e.acc)});
          if (lat_chk) chk("latency", cyc - last_in, e.gap);
        end
        if (k == 0) n_ld++;
        if (k == 1) begin if (n_cp < 64) acc_log[n_cp] = int'(acc); n_cp++; end
        if (k == 2) begin
          if (n_st < 32) begin st_row[n_st] = int'(trow); st_col[n_st] = int'(tcol); st_in[n_st] = int'(tin); end
          n_st++;
        end
        if (k == 3) begin n_cd++; saw_done = 1'b1; cd_cyc = cyc; end
      end
    end
    if (ld_st1) n_ld1++;
    if (cp_st1) begin n_cp1++; acc1_seen = int'(acc1); idx1 = {trow1, tcol1, tin1, tout1}; end
    if (st_st1) n_st1++;
    if (st_dn1) begin sd1_cyc = cyc; busy1_at_sd = busy1; end
    if (cdone1) begin n_cd1++; cd1_cyc = cyc; end
    if (ld_dn || cp_dn || st_dn || (cs && !exp_busy)) last_in = cyc;
    if (cdone) exp_busy = 1'b0;
    else if (cs) exp_busy = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
    rst = p_rst; cs = p_cs; cs1 = p_cs1;
    ld_sp = p_ld; cp_sp = p_cp; st_sp = p_st;
    p_rst = 1'b0; p_cs = 1'b0; p_cs1 = 1'b0; p_ld = 1'b0; p_cp = 1'b0; p_st = 1'b0;
    resp(c_ld, ld_r, ld_st, d_ld);
    resp(c_cp, cp_r, cp_st, d_cp);
    resp(c_st, st_r, st_st, d_st);
    resp(c_ld1, ld_dn1, ld_st1, 1);
    resp(c_cp1, cp_dn1, cp_st1, 1);
    resp(c_st1, st_dn1, st_st1, d_st1);
    @(negedge clk);
    check();
  endtask

  task automatic run_layer(input int maxc, input bit spur);
    saw_done = 1'b0;
    build();
    p_cs = 1'b1;
    tick();
    cs_cyc = cyc;
    for (int n = 0; n < maxc && !saw_done; n++) begin
      if (spur) begin
        if (ld_st) p_cp = 1'b1;   // lands in the first WAIT_LOAD cycle
        if (st_r)  p_st = 1'b1;   // stretches store_done into a second cycle
        if (n == 20) p_cs = 1'b1; // restart attempt mid-layer
      end
      tick();
    end
    chk("layer_done_seen", saw_done, 1);
    repeat (3) tick();
    chk("model_drained", q.size(), 0);
  endtask

  task automatic chk_counts(input string nm, input int b_ld, input int b_cp, input int b_st, input int b_cd);
    chk({nm, "_loads"}, n_ld - b_ld, 8);
    chk({nm, "_computes"}, n_cp - b_cp, 8);
    chk({nm, "_stores"}, n_st - b_st, 4);
    chk({nm, "_done"}, n_cd - b_cd, 1);
  endtask

  initial begin
    int b_ld, b_cp, b_st, b_cd, b_st5;
    int exp_r[4] = '{0, 0, 1, 1};
    int exp_c[4] = '{0, 1, 0, 1};
    int exp_acc[8] = '{1, 0, 1, 0, 1, 0, 1, 0};

    repeat (3) begin p_rst = 1'b1; tick(); end
    tick();
    chk("reset_outputs", {ld_st, cp_st, acc, st_st, busy, cdone, trow, tcol, tin, tout}, '0);
    chk("reset_outputs1", {ld_st1, cp_st1, acc1, st_st1, busy1, cdone1}, '0);

    // 1/2: 3-cycle responders, counts, store order, acc_clear pattern
    b_ld = n_ld; b_cp = n_cp; b_st = n_st; b_cd = n_cd;
    run_layer(400, 1'b0);
    chk_counts("t1", b_ld, b_cp, b_st, b_cd);
    for (int j = 0; j < 4; j++) begin
      chk("t1_store_row", st_row[b_st + j], exp_r[j]);
      chk("t1_store_col", st_col[b_st + j], exp_c[j]);
      chk("t2_store_in", st_in[b_st + j], 1);
    end
    for (int j = 0; j < 8; j++) chk("t2_acc_clear", acc_log[b_cp + j], exp_acc[j]);

    // 3: immediate responders, cycle-exact latency
    d_ld = 1; d_cp = 1; d_st = 1; lat_chk = 1'b1;
    run_layer(200, 1'b0);
    chk("t3_layer_cycles", cd_cyc - cs_cyc, 45);
    chk("t3_busy_after_done", busy, 0);
    lat_chk = 1'b0;

    // 4: stray done pulses and a mid-layer conv_start
    d_ld = 3; d_cp = 3; d_st = 3;
    p_st = 1'b1; tick();
    tick();
    chk("t4_idle_after_stray", {busy, ld_st}, 0);
    b_ld = n_ld; b_cp = n_cp; b_st = n_st; b_cd = n_cd;
    run_layer(400, 1'b1);
    chk_counts("t4", b_ld, b_cp, b_st, b_cd);

    // 5: reset during WAIT_STORE of the second tile, late store_done dropped
    b_st5 = n_st;
    saw_done = 1'b0;
    build();
    p_cs = 1'b1; tick();
    for (int n = 0; n < 200 && (n_st - b_st5) < 2; n++) tick();
    chk("t5_second_store_seen", n_st - b_st5, 2);
    p_rst = 1'b1; tick();
    repeat (6) tick();
    chk("t5_idle_after_reset", {busy, trow, tcol, tin, tout}, 0);
    b_ld = n_ld; b_cp = n_cp; b_st = n_st; b_cd = n_cd;
    run_layer(400, 1'b0);
    chk_counts("t5", b_ld, b_cp, b_st, b_cd);
    chk("t5_first_store_idx", {st_row[b_st], st_col[b_st]}, 0);

    // 6: all counts 1, store_done 100 cycles late
    p_cs1 = 1'b1; tick();
    cs1_cyc = cyc;
    for (int n = 0; n < 300 && cd1_cyc < 0; n++) tick();
    repeat (5) tick();
    chk("t6_done_after_store", cd1_cyc - sd1_cyc, 2);
    chk("t6_layer_cycles", cd1_cyc - cs1_cyc, 107);
    chk("t6_counts", {8'(n_ld1), 8'(n_cp1), 8'(n_st1), 8'(n_cd1)}, 32'h01010101);
    chk("t6_acc_clear", acc1_seen, 1);
    chk("t6_indices", idx1, 0);
    chk("t6_busy_during_store", busy1_at_sd, 1);
    chk("t6_busy_end", busy1, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
